// File: rtl/if_stage_fq_pkg.sv
// rtl/if_stage_fq_pkg.sv - shared constants and helpers for the fetch stage
package if_stage_fq_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0033;
    localparam int          IF_ID_BUS_W  = 64;
    localparam int          BUS_PC_LSB   = 0;
    localparam int          BUS_INST_LSB = 32;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - DEPTH-entry sync FIFO holding fetched {inst,pc} pairs
module if_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so wrap is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_stage_fq.sv
// rtl/if_stage_fq.sv - instruction fetch stage with credit-based decoupling queue
module if_stage_fq
    import if_stage_fq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    input  logic                   trap_valid,
    input  logic [31:0]            trap_target,
    input  logic                   ds_allowin,
    output logic                   fs_to_ds_valid,
    output logic [IF_ID_BUS_W-1:0] if_id_bus_out
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            req_pc_q, req_pc_d;
    logic                   inflight_q, inflight_d;
    logic                   flush, squash, push, pop, credit_ok;
    logic [31:0]            next_addr, inst;
    logic [PW+1:0]          occupancy;
    logic [PW:0]            fifo_count;
    logic                   fifo_full, fifo_empty;
    logic [IF_ID_BUS_W-1:0] push_data, head_data;

    assign flush     = redirect_valid || trap_valid;
    assign next_addr = redirect_valid ? redirect_target :
                       trap_valid     ? trap_target     : fetch_pc_q;
    assign imem_addr = next_addr;

    // A redirect both clears the queue and kills the response landing this cycle.
    assign squash         = flush;
    assign fs_to_ds_valid = !fifo_empty && !flush && !rst;
    assign pop            = fs_to_ds_valid && ds_allowin;

    assign occupancy = {1'b0, fifo_count} + (PW+2)'(inflight_q);
    assign credit_ok = occupancy < (PW+2)'(DEPTH);
    assign imem_req  = !rst && (flush || credit_ok || pop);

    assign push = inflight_q && !squash;
    assign inst = SWAP_BYTES ? bswap32(imem_rdata) : imem_rdata;

    always_comb begin
        push_data = '0;
        push_data[BUS_INST_LSB +: 32] = inst;
        push_data[BUS_PC_LSB   +: 32] = req_pc_q;
    end

    assign if_id_bus_out = fs_to_ds_valid ? head_data : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        if (imem_req) begin
            fetch_pc_d = next_addr + 32'd4;
            req_pc_d   = next_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (IF_ID_BUS_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_data),
        .rdata_o (head_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));

endmodule
